// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D cache memory bus arbiter.
package mem_arb_pkg;

    localparam int unsigned LINE_BEATS_DEF = 8;
    localparam int unsigned OP_BIT         = 12;

    // Tag op-bit value that marks a write transaction.
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

endpackage

// File: rtl/arb_rr_picker.sv
// Two-way combinational grant picker.
//   req   : {d_req, i_req} request lines (bit index = req_id_e value)
//   last  : requester that owned the bus most recently
//   rr_en : 1 = round-robin on contention, 0 = fixed priority (D beats I)
//   grant : selected requester (only meaningful when req != 0)
module arb_rr_picker
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    last,
    input  logic       rr_en,
    output req_id_e    grant
);

    // On contention round-robin picks whoever did not go last; otherwise D wins.
    always_comb begin
        grant = REQ_D;
        if (req[1] && req[0]) begin
            grant = (rr_en && (last == REQ_D)) ? REQ_I : REQ_D;
        end else if (req[0]) begin
            grant = REQ_I;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the DRAM-side memory bus between the instruction cache (i_*) and the
// data cache (d_*). One requester owns the bus for a whole line transaction:
// read = address beat + LINE_BEATS response beats, write = address beat +
// LINE_BEATS data beats. Unsolicited responses arriving while idle go to d_*.
//   clk, reset (async, active-low)
//   i_*/d_*  : cache-side request (reqcyc/reqack/req/reqtag) and
//              response (respcyc/respack/resp/resptag) channels
//   m_bus_*  : memory-side request and response channels
// Build option: define MEMARB_RR_EN for round-robin arbitration (default is
// fixed priority, data cache first).
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned LINE_BEATS     = LINE_BEATS_DEF
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      i_reqcyc,
    output logic                      i_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] i_req,
    input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
    output logic                      i_respcyc,
    input  logic                      i_respack,
    output logic [BUS_DATA_WIDTH-1:0] i_resp,
    output logic [BUS_TAG_WIDTH-1:0]  i_resptag,

    input  logic                      d_reqcyc,
    output logic                      d_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] d_req,
    input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
    output logic                      d_respcyc,
    input  logic                      d_respack,
    output logic [BUS_DATA_WIDTH-1:0] d_resp,
    output logic [BUS_TAG_WIDTH-1:0]  d_resptag,

    output logic                      m_bus_reqcyc,
    input  logic                      m_bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
    input  logic                      m_bus_respcyc,
    output logic                      m_bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag
);

    localparam int unsigned CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

`ifdef MEMARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    arb_state_e       state_q, state_d;
    req_id_e          owner_q, owner_d;
    req_id_e          rr_last_q, rr_last_d;
    logic             op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    req_id_e          winner;

    logic                      own_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] own_req;
    logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
    logic                      own_respack;
    logic [BUS_TAG_WIDTH-1:0]  win_reqtag;
    logic                      req_fire;
    logic                      resp_fire;

    arb_rr_picker u_picker (
        .req   ({d_reqcyc, i_reqcyc}),
        .last  (rr_last_q),
        .rr_en (RR_EN),
        .grant (winner)
    );

    // Owner-side request/response selection.
    assign own_reqcyc  = (owner_q == REQ_D) ? d_reqcyc  : i_reqcyc;
    assign own_req     = (owner_q == REQ_D) ? d_req     : i_req;
    assign own_reqtag  = (owner_q == REQ_D) ? d_reqtag  : i_reqtag;
    assign own_respack = (owner_q == REQ_D) ? d_respack : i_respack;
    assign win_reqtag  = (winner  == REQ_D) ? d_reqtag  : i_reqtag;

    assign req_fire  = own_reqcyc & m_bus_reqack;
    assign resp_fire = m_bus_respcyc & own_respack;

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= REQ_D;
            rr_last_q <= REQ_I;
            op_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic: grant in IDLE, then track beats until the line is done.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                // An unsolicited response occupies the cycle; arbitration waits.
                if (!m_bus_respcyc && (i_reqcyc || d_reqcyc)) begin
                    owner_d = winner;
                    op_d    = win_reqtag[OP_BIT];
                    cnt_d   = '0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (req_fire) begin
                    cnt_d   = '0;
                    state_d = (op_q == OP_WRITE) ? WDATA : RDATA;
                end
            end
            WDATA: begin
                if (req_fire) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d     = '0;
                        rr_last_d = owner_q;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RDATA: begin
                if (resp_fire) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d     = '0;
                        rr_last_d = owner_q;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output forwarding from registered state; everything quiet while in reset.
    always_comb begin
        i_reqack      = 1'b0;
        d_reqack      = 1'b0;
        i_respcyc     = 1'b0;
        d_respcyc     = 1'b0;
        i_resp        = '0;
        d_resp        = '0;
        i_resptag     = '0;
        d_resptag     = '0;
        m_bus_reqcyc  = 1'b0;
        m_bus_req     = '0;
        m_bus_reqtag  = '0;
        m_bus_respack = 1'b0;
        if (reset) begin
            unique case (state_q)
                IDLE: begin
                    if (m_bus_respcyc) begin
                        d_respcyc     = 1'b1;
                        d_resp        = m_bus_resp;
                        d_resptag     = m_bus_resptag;
                        m_bus_respack = d_respack;
                    end
                end
                ADDR, WDATA: begin
                    m_bus_reqcyc = own_reqcyc;
                    m_bus_req    = own_req;
                    m_bus_reqtag = own_reqtag;
                    if (owner_q == REQ_D) d_reqack = m_bus_reqack;
                    else                  i_reqack = m_bus_reqack;
                end
                RDATA: begin
                    m_bus_respack = own_respack;
                    if (owner_q == REQ_D) begin
                        d_respcyc = m_bus_respcyc;
                        d_resp    = m_bus_resp;
                        d_resptag = m_bus_resptag;
                    end else begin
                        i_respcyc = m_bus_respcyc;
                        i_resp    = m_bus_resp;
                        i_resptag = m_bus_resptag;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: the bench plays both caches and the
// memory, drives one vector per cycle and compares every DUT output.
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic        ireqcyc;
        logic [63:0] ireq;
        logic [12:0] itag;
        logic        dreqcyc;
        logic [63:0] dreq;
        logic [12:0] dtag;
        logic        mack;
        logic        mrespcyc;
        logic [63:0] mresp;
        logic [12:0] mresptag;
        logic        irespack;
        logic        drespack;
    } in_t;

    typedef struct packed {
        logic        mreqcyc;
        logic        iack;
        logic        dack;
        logic        irespcyc;
        logic        drespcyc;
        logic        mrespack;
        logic [63:0] mreq;
        logic [12:0] mreqtag;
        logic [63:0] iresp;
        logic [12:0] iresptag;
        logic [63:0] dresp;
        logic [12:0] dresptag;
    } out_t;

    typedef struct {
        string nm;
        in_t   i;
        out_t  o;
    } vec_t;

    localparam logic [63:0] OTH_A = 64'h3000;
    localparam logic [12:0] OTH_T = 13'h0007;

    logic clk = 1'b0;
    logic reset;

    logic        i_reqcyc, i_reqack, i_respcyc, i_respack;
    logic [63:0] i_req, i_resp;
    logic [12:0] i_reqtag, i_resptag;
    logic        d_reqcyc, d_reqack, d_respcyc, d_respack;
    logic [63:0] d_req, d_resp;
    logic [12:0] d_reqtag, d_resptag;
    logic        m_bus_reqcyc, m_bus_reqack, m_bus_respcyc, m_bus_respack;
    logic [63:0] m_bus_req, m_bus_resp;
    logic [12:0] m_bus_reqtag, m_bus_resptag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .i_reqcyc      (i_reqcyc),
        .i_reqack      (i_reqack),
        .i_req         (i_req),
        .i_reqtag      (i_reqtag),
        .i_respcyc     (i_respcyc),
        .i_respack     (i_respack),
        .i_resp        (i_resp),
        .i_resptag     (i_resptag),
        .d_reqcyc      (d_reqcyc),
        .d_reqack      (d_reqack),
        .d_req         (d_req),
        .d_reqtag      (d_reqtag),
        .d_respcyc     (d_respcyc),
        .d_respack     (d_respack),
        .d_resp        (d_resp),
        .d_resptag     (d_resptag),
        .m_bus_reqcyc  (m_bus_reqcyc),
        .m_bus_reqack  (m_bus_reqack),
        .m_bus_req     (m_bus_req),
        .m_bus_reqtag  (m_bus_reqtag),
        .m_bus_respcyc (m_bus_respcyc),
        .m_bus_respack (m_bus_respack),
        .m_bus_resp    (m_bus_resp),
        .m_bus_resptag (m_bus_resptag)
    );

    function automatic in_t rq(input logic ic, input logic [63:0] ia, input logic [12:0] it,
                               input logic dc, input logic [63:0] da, input logic [12:0] dt,
                               input logic mack);
        in_t v;
        v = '0;
        v.ireqcyc = ic; v.ireq = ia; v.itag = it;
        v.dreqcyc = dc; v.dreq = da; v.dtag = dt;
        v.mack = mack;
        return v;
    endfunction

    function automatic in_t rs(input in_t b, input logic mc, input logic [63:0] data,
                               input logic [12:0] tag, input logic ia, input logic da);
        in_t v;
        v = b;
        v.mrespcyc = mc; v.mresp = data; v.mresptag = tag;
        v.irespack = ia; v.drespack = da;
        return v;
    endfunction

    // Expected outputs while the owner's request is on the memory bus.
    function automatic out_t ea(input logic own_d, input logic [63:0] a,
                                input logic [12:0] t, input logic ack);
        out_t e;
        e = '0;
        e.mreqcyc = 1'b1; e.mreq = a; e.mreqtag = t;
        if (own_d) e.dack = ack; else e.iack = ack;
        return e;
    endfunction

    // Expected outputs while a memory response is routed to one cache.
    function automatic out_t er(input logic to_d, input logic cyc, input logic [63:0] data,
                                input logic [12:0] tag, input logic ack);
        out_t e;
        e = '0;
        e.mrespack = ack;
        if (to_d) begin
            e.drespcyc = cyc; e.dresp = data; e.dresptag = tag;
        end else begin
            e.irespcyc = cyc; e.iresp = data; e.iresptag = tag;
        end
        return e;
    endfunction

    task automatic apply(input in_t v);
        i_reqcyc = v.ireqcyc; i_req = v.ireq; i_reqtag = v.itag;
        d_reqcyc = v.dreqcyc; d_req = v.dreq; d_reqtag = v.dtag;
        m_bus_reqack = v.mack;
        m_bus_respcyc = v.mrespcyc; m_bus_resp = v.mresp; m_bus_resptag = v.mresptag;
        i_respack = v.irespack; d_respack = v.drespack;
    endtask

    task automatic check(input string nm, input out_t e);
        out_t got;
        got = {m_bus_reqcyc, i_reqack, d_reqack, i_respcyc, d_respcyc, m_bus_respack,
               m_bus_req, m_bus_reqtag, i_resp, i_resptag, d_resp, d_resptag};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, e);
        end
    endtask

    task automatic step(input string nm, input in_t v, input out_t e);
        @(negedge clk);
        apply(v);
        #1;
        check(nm, e);
    endtask

    // Full read line: IDLE grant cycle, address beat, LINE_BEATS responses.
    // When 'other' is set the non-owner keeps requesting throughout.
    task automatic read_txn(input logic own_d, input logic other, input logic [63:0] addr,
                            input logic [12:0] tag, input logic [63:0] base, input string nm);
        in_t v;
        v = own_d ? rq(other, OTH_A, OTH_T, 1'b1, addr, tag, 1'b0)
                  : rq(1'b1, addr, tag, other, OTH_A, OTH_T, 1'b0);
        step({nm, "_idle"}, v, '0);
        v.mack = 1'b1;
        step({nm, "_addr"}, v, ea(own_d, addr, tag, 1'b1));
        for (int k = 0; k < 8; k++) begin
            v = own_d ? rq(other, OTH_A, OTH_T, 1'b0, 64'h0, 13'h0, 1'b0)
                      : rq(1'b0, 64'h0, 13'h0, other, OTH_A, OTH_T, 1'b0);
            v = rs(v, 1'b1, base + 64'(k), tag, ~own_d, own_d);
            step({nm, "_beat"}, v, er(own_d, 1'b1, base + 64'(k), tag, 1'b1));
        end
    endtask

    vec_t tbl[$];

    initial begin
        in_t v;
        vec_t r;

        // Table for scenario: lone i-cache read with one stalled response beat.
        v = rq(1'b1, 64'h1000, 13'h0005, 1'b0, 64'h0, 13'h0, 1'b0);
        r.nm = "t1_idle"; r.i = v; r.o = '0; tbl.push_back(r);
        v.mack = 1'b1;
        r.nm = "t1_addr"; r.i = v; r.o = ea(1'b0, 64'h1000, 13'h0005, 1'b1); tbl.push_back(r);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                r.nm = "t1_stall";
                r.i = rs('0, 1'b1, 64'h1111_0000 + 64'(k), 13'h0005, 1'b0, 1'b0);
                r.o = er(1'b0, 1'b1, 64'h1111_0000 + 64'(k), 13'h0005, 1'b0);
                tbl.push_back(r);
            end
            r.nm = "t1_beat";
            r.i = rs('0, 1'b1, 64'h1111_0000 + 64'(k), 13'h0005, 1'b1, 1'b0);
            r.o = er(1'b0, 1'b1, 64'h1111_0000 + 64'(k), 13'h0005, 1'b1);
            tbl.push_back(r);
        end
        r.nm = "t1_unsol";
        r.i = rs('0, 1'b1, 64'hBEEF, 13'h0800, 1'b0, 1'b1);
        r.o = er(1'b1, 1'b1, 64'hBEEF, 13'h0800, 1'b1);
        tbl.push_back(r);
        r.nm = "t1_quiet"; r.i = '0; r.o = '0; tbl.push_back(r);

        // Reset: outputs silent even with every input active.
        reset = 1'b0;
        apply(rs(rq(1'b1, 64'h11, 13'h1001, 1'b1, 64'h22, 13'h1002, 1'b1),
                 1'b1, 64'h33, 13'h0800, 1'b1, 1'b1));
        @(negedge clk);
        #1;
        check("t0_reset", '0);
        @(negedge clk);
        apply('0);
        reset = 1'b1;

        // Simultaneous requests straight out of reset.
        read_txn(1'b1, 1'b1, 64'h7000, 13'h0011, 64'hD000, "t3_p1_d");
        read_txn(1'b0, 1'b0, OTH_A, OTH_T, 64'hA000, "t3_p1_i");
        read_txn(1'b1, 1'b1, 64'h7040, 13'h0012, 64'hD100, "t3_p2_d");
        read_txn(1'b0, 1'b0, OTH_A, OTH_T, 64'hA100, "t3_p2_i");
        read_txn(1'b1, 1'b1, 64'h7080, 13'h0013, 64'hD200, "t3_p3_d");
`ifdef MEMARB_RR_EN
        read_txn(1'b0, 1'b1, OTH_A, OTH_T, 64'hA200, "t3_p3_i");
        read_txn(1'b1, 1'b0, 64'h70C0, 13'h0014, 64'hD300, "t3_p4_d");
`else
        read_txn(1'b1, 1'b1, 64'h70C0, 13'h0014, 64'hD300, "t3_p3_dd");
        read_txn(1'b0, 1'b0, OTH_A, OTH_T, 64'hA200, "t3_p3_i");
`endif

        foreach (tbl[n]) step(tbl[n].nm, tbl[n].i, tbl[n].o);

        // d-cache line write, i-cache requesting meanwhile but never acked.
        v = rq(1'b0, 64'h0, 13'h0, 1'b1, 64'h2040, 13'h1040, 1'b0);
        step("t2_idle", v, '0);
        step("t2_addr_wait", v, ea(1'b1, 64'h2040, 13'h1040, 1'b0));
        v.mack = 1'b1;
        step("t2_addr", v, ea(1'b1, 64'h2040, 13'h1040, 1'b1));
        for (int k = 0; k < 8; k++) begin
            v = rq(1'b1, 64'h5000, 13'h0003, 1'b1, 64'(k), 13'h1040, 1'b0);
            if (k == 2) step("t2_wstall", v, ea(1'b1, 64'(k), 13'h1040, 1'b0));
            v.mack = 1'b1;
            step("t2_wdata", v, ea(1'b1, 64'(k), 13'h1040, 1'b1));
        end
        read_txn(1'b0, 1'b0, 64'h5000, 13'h0003, 64'hC000, "t2_then_i");

        // Unsolicited response in IDLE blocks arbitration of a waiting i request.
        v = rs(rq(1'b1, 64'h8000, 13'h0002, 1'b0, 64'h0, 13'h0, 1'b0),
               1'b1, 64'hDEAD, 13'h0800, 1'b0, 1'b1);
        step("t4_unsol_ack", v, er(1'b1, 1'b1, 64'hDEAD, 13'h0800, 1'b1));
        v.drespack = 1'b0;
        step("t4_unsol_wait", v, er(1'b1, 1'b1, 64'hDEAD, 13'h0800, 1'b0));
        read_txn(1'b0, 1'b0, 64'h8000, 13'h0002, 64'hE000, "t4_i");

        // Reset in the middle of a read line.
        v = rq(1'b1, 64'h9000, 13'h0006, 1'b0, 64'h0, 13'h0, 1'b0);
        step("t5_idle", v, '0);
        v.mack = 1'b1;
        step("t5_addr", v, ea(1'b0, 64'h9000, 13'h0006, 1'b1));
        for (int k = 0; k < 4; k++) begin
            v = rs('0, 1'b1, 64'hF000 + 64'(k), 13'h0006, 1'b1, 1'b0);
            step("t5_beat", v, er(1'b0, 1'b1, 64'hF000 + 64'(k), 13'h0006, 1'b1));
        end
        @(negedge clk);
        apply(rs(rq(1'b1, 64'h9000, 13'h0006, 1'b0, 64'h0, 13'h0, 1'b1),
                 1'b1, 64'hF004, 13'h0006, 1'b1, 1'b1));
        reset = 1'b0;
        #1;
        check("t5_rst_now", '0);
        @(negedge clk);
        #1;
        check("t5_rst_hold", '0);
        apply('0);
        reset = 1'b1;
        read_txn(1'b1, 1'b0, 64'h6000, 13'h0004, 64'hB000, "t5_d");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
